ctrl_poly_fsm: RTL and testbench

Parametrised successor to the upsampler controller FSM. It sequences the polyphase upsampling data flow across NUM_STAGES cascaded stages and NUM_VECTORS output vectors per input sample. Internal loop counters generate the tap, stage and vector indices and their "last" flags. Ready/valid handshakes connect to the audio input bus and the system output, and a synchronous flush is provided. It sits between the audio bus and the MAC/regfile/RAM datapath, which decodes ostate and the indices.

---
 rtl/ctrl_poly_fsm_pkg.sv | 53 +++++
 rtl/ctrl_loop_cnt.sv | 47 ++++
 rtl/ctrl_poly_fsm.sv | 230 +++++++++++++++++++++++
 tb/tb_ctrl_poly_fsm.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_poly_fsm_pkg.sv
// ----------------------------------------------------------------------------
// ctrl_poly_fsm_pkg
//   Shared definitions for the polyphase upsampler controller and the
//   datapath decoders that interpret its ostate output.
//   Contents:
//     CTRL_STATE_W         width of the state encoding (4)
//     CTRL_S_IDLE..PC_INC  fixed numeric state encodings seen on ostate
//     ctrl_state_e         FSM state enum built on those encodings
//     pc_src_e             which state led into PC_INC (selects counter update)
//     idx_w()              index width for a loop count ($clog2, minimum 1)
// ----------------------------------------------------------------------------
package ctrl_poly_fsm_pkg;

  localparam int CTRL_STATE_W = 4;

  // Numeric encodings are part of the datapath contract; do not reorder.
  localparam logic [CTRL_STATE_W-1:0] CTRL_S_IDLE      = 4'd0;
  localparam logic [CTRL_STATE_W-1:0] CTRL_S_ALLOC     = 4'd1;
  localparam logic [CTRL_STATE_W-1:0] CTRL_S_LOAD_INIT = 4'd2;
  localparam logic [CTRL_STATE_W-1:0] CTRL_S_CONV      = 4'd3;
  localparam logic [CTRL_STATE_W-1:0] CTRL_S_LOAD_RES  = 4'd4;
  localparam logic [CTRL_STATE_W-1:0] CTRL_S_LOAD_ERR  = 4'd5;
  localparam logic [CTRL_STATE_W-1:0] CTRL_S_LOAD_OUT  = 4'd6;
  localparam logic [CTRL_STATE_W-1:0] CTRL_S_LOAD_IN   = 4'd7;
  localparam logic [CTRL_STATE_W-1:0] CTRL_S_PC_INC    = 4'd8;

  typedef enum logic [CTRL_STATE_W-1:0] {
    S_IDLE      = CTRL_S_IDLE,
    S_ALLOC     = CTRL_S_ALLOC,
    S_LOAD_INIT = CTRL_S_LOAD_INIT,
    S_CONV      = CTRL_S_CONV,
    S_LOAD_RES  = CTRL_S_LOAD_RES,
    S_LOAD_ERR  = CTRL_S_LOAD_ERR,
    S_LOAD_OUT  = CTRL_S_LOAD_OUT,
    S_LOAD_IN   = CTRL_S_LOAD_IN,
    S_PC_INC    = CTRL_S_PC_INC
  } ctrl_state_e;

  // PC_INC performs a different index update depending on where it came from.
  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_ERR  = 2'd1,
    SRC_OUT  = 2'd2,
    SRC_IN   = 2'd3
  } pc_src_e;

  // Index width for a loop of 'count' iterations; a count of 1 still gets
  // a 1-bit index so ports never collapse to zero width.
  function automatic int idx_w(input int count);
    return (count > 1) ? $clog2(count) : 1;
  endfunction

endpackage

// File: rtl/ctrl_loop_cnt.sv
// ----------------------------------------------------------------------------
// ctrl_loop_cnt
//   Loop index counter used for the tap, stage and vector loops.
//   Parameters:
//     COUNT  number of iterations (>=1); idx runs 0..COUNT-1
//     W      index width
//   Ports:
//     clk    clock
//     rst    asynchronous active-low reset (idx -> 0)
//     en     clock enable; idx holds when 0
//     clr    synchronous clear to 0 (wins over inc)
//     inc    advance by one; wraps to 0 after COUNT-1
//     idx    current index
//     last   idx == COUNT-1 (constant 1 when COUNT == 1)
// ----------------------------------------------------------------------------
module ctrl_loop_cnt
  import ctrl_poly_fsm_pkg::*;
#(
  parameter int COUNT = 2,
  parameter int W     = idx_w(COUNT)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] idx,
  output logic         last
);

  assign last = (idx == W'(COUNT - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx <= '0;
    end else if (en) begin
      if (clr) begin
        idx <= '0;
      end else if (inc) begin
        // The controller never increments past the last index, but wrap
        // keeps the counter inside 0..COUNT-1 regardless.
        idx <= last ? '0 : idx + W'(1);
      end
    end
  end

endmodule

// File: rtl/ctrl_poly_fsm.sv
// ----------------------------------------------------------------------------
// ctrl_poly_fsm
//   Polyphase upsampler sequencer. For every input sample it runs NUM_VECTORS
//   output vectors, each through NUM_STAGES cascaded stages, each stage a
//   NUM_TAPS-cycle convolution. The MAC/regfile/RAM datapath decodes ostate
//   and the loop indices.
//
//   Optional build macro: CTRL_STALL_CNT_EN
//     defined   : stall_cnt counts enabled handshake-stall cycles (saturating)
//     undefined : stall_cnt is tied to 0
//
//   Parameters: NUM_STAGES, NUM_VECTORS, NUM_TAPS (each >=1)
//   Ports:
//     clk, rst     clock, asynchronous active-low reset
//     en           clock enable for all state and counters
//     flush        synchronous abort to IDLE (only when en=1)
//     in_valid     audio bus sample valid
//     in_ready     controller accepts a sample (LOAD_IN)
//     out_valid    output sample valid (LOAD_OUT)
//     out_ready    downstream accepts output sample
//     ostate       4-bit state encoding (also the FSM debug view)
//     stage_idx    current stage
//     vec_idx      current vector
//     tap_idx      current tap, meaningful in CONV
//     busy         state != IDLE
//     frame_done   one-cycle pulse on an accepted input sample
//     stall_cnt    handshake stall counter
// ----------------------------------------------------------------------------
module ctrl_poly_fsm
  import ctrl_poly_fsm_pkg::*;
#(
  parameter  int NUM_STAGES  = 4,
  parameter  int NUM_VECTORS = 2,
  parameter  int NUM_TAPS    = 16,
  localparam int SW          = idx_w(NUM_STAGES),
  localparam int VW          = idx_w(NUM_VECTORS),
  localparam int TW          = idx_w(NUM_TAPS)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    flush,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [CTRL_STATE_W-1:0] ostate,
  output logic [SW-1:0]           stage_idx,
  output logic [VW-1:0]           vec_idx,
  output logic [TW-1:0]           tap_idx,
  output logic                    busy,
  output logic                    frame_done,
  output logic [15:0]             stall_cnt
);

  ctrl_state_e state, state_nxt;
  pc_src_e     src, src_nxt;

  logic tap_clr, tap_inc, tap_last;
  logic stg_clr, stg_inc, stg_last;
  logic vec_clr, vec_inc, vec_last;
  logic out_xfer, in_xfer;

  // Handshakes: in_ready and out_valid are pure state decodes (no path from
  // in_valid/out_ready). A transfer happens on a clk edge where valid, ready
  // and en are all high; a same-cycle flush cancels the transfer.
  assign out_valid = (state == S_LOAD_OUT);
  assign in_ready  = (state == S_LOAD_IN);
  assign out_xfer  = out_valid & out_ready & en & ~flush;
  assign in_xfer   = in_ready & in_valid & en & ~flush;

  assign frame_done = in_xfer;
  assign busy       = (state != S_IDLE);
  assign ostate     = state;

  // --------------------------------------------------------------------------
  // Loop counters
  // --------------------------------------------------------------------------
  ctrl_loop_cnt #(.COUNT(NUM_TAPS), .W(TW)) u_tap_cnt (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .clr  (tap_clr),
    .inc  (tap_inc),
    .idx  (tap_idx),
    .last (tap_last)
  );

  ctrl_loop_cnt #(.COUNT(NUM_STAGES), .W(SW)) u_stage_cnt (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .clr  (stg_clr),
    .inc  (stg_inc),
    .idx  (stage_idx),
    .last (stg_last)
  );

  ctrl_loop_cnt #(.COUNT(NUM_VECTORS), .W(VW)) u_vec_cnt (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .clr  (vec_clr),
    .inc  (vec_inc),
    .idx  (vec_idx),
    .last (vec_last)
  );

  // --------------------------------------------------------------------------
  // FSM state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
      src   <= SRC_NONE;
    end else if (en) begin
      state <= state_nxt;
      src   <= src_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Next state and counter controls
  // --------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    src_nxt   = src;
    tap_clr   = 1'b0;
    tap_inc   = 1'b0;
    stg_clr   = 1'b0;
    stg_inc   = 1'b0;
    vec_clr   = 1'b0;
    vec_inc   = 1'b0;

    case (state)
      S_IDLE:      state_nxt = S_ALLOC;
      S_ALLOC:     state_nxt = S_LOAD_INIT;
      S_LOAD_INIT: begin
        state_nxt = S_CONV;
        tap_clr   = 1'b1;
      end
      S_CONV: begin
        // Tap index holds at NUM_TAPS-1 on exit; LOAD_INIT re-zeroes it.
        if (tap_last) state_nxt = S_LOAD_RES;
        else          tap_inc   = 1'b1;
      end
      S_LOAD_RES:  state_nxt = S_LOAD_ERR;
      S_LOAD_ERR: begin
        if (!stg_last) begin
          state_nxt = S_PC_INC;
          src_nxt   = SRC_ERR;
        end else begin
          state_nxt = S_LOAD_OUT;
        end
      end
      S_LOAD_OUT: begin
        if (out_xfer) begin
          if (!vec_last) begin
            state_nxt = S_PC_INC;
            src_nxt   = SRC_OUT;
          end else begin
            state_nxt = S_LOAD_IN;
          end
        end
      end
      S_LOAD_IN: begin
        if (in_xfer) begin
          state_nxt = S_PC_INC;
          src_nxt   = SRC_IN;
        end
      end
      S_PC_INC: begin
        state_nxt = S_ALLOC;
        src_nxt   = SRC_NONE;
        case (src)
          SRC_ERR: stg_inc = 1'b1;
          SRC_OUT: begin
            stg_clr = 1'b1;
            vec_inc = 1'b1;
          end
          SRC_IN: begin
            stg_clr = 1'b1;
            vec_clr = 1'b1;
          end
          default: ;
        endcase
      end
      default:     state_nxt = S_IDLE;
    endcase

    // Flush overrides everything decided above, including handshakes.
    if (flush) begin
      state_nxt = S_IDLE;
      src_nxt   = SRC_NONE;
      tap_clr   = 1'b1;
      tap_inc   = 1'b0;
      stg_clr   = 1'b1;
      stg_inc   = 1'b0;
      vec_clr   = 1'b1;
      vec_inc   = 1'b0;
    end
  end

  // --------------------------------------------------------------------------
  // Handshake stall counter
  // --------------------------------------------------------------------------
`ifdef CTRL_STALL_CNT_EN
  logic [15:0] stall_q;
  logic        stall_cond;

  assign stall_cond = (out_valid & ~out_ready) | (in_ready & ~in_valid);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_q <= '0;
    end else if (en) begin
      if (flush) begin
        stall_q <= '0;
      end else if (stall_cond && (stall_q != 16'hFFFF)) begin
        stall_q <= stall_q + 16'd1;
      end
    end
  end

  assign stall_cnt = stall_q;
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_ctrl_poly_fsm.sv
module tb_ctrl_poly_fsm;

  // --------------------------------------------------------------------------
  // Clock / reset
  // --------------------------------------------------------------------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Main DUT (default parameters)
  logic        en, flush, in_valid, out_ready;
  logic        in_ready, out_valid, busy, frame_done;
  logic [3:0]  ostate;
  logic [1:0]  stage_idx;
  logic [0:0]  vec_idx;
  logic [3:0]  tap_idx;
  logic [15:0] stall_cnt;

  ctrl_poly_fsm dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .ostate     (ostate),
    .stage_idx  (stage_idx),
    .vec_idx    (vec_idx),
    .tap_idx    (tap_idx),
    .busy       (busy),
    .frame_done (frame_done),
    .stall_cnt  (stall_cnt)
  );

  // Degenerate DUT: one stage, one vector, one tap, always-ready handshakes
  logic        d1_en, d1_flush, d1_in_valid, d1_out_ready;
  logic        d1_in_ready, d1_out_valid, d1_busy, d1_frame_done;
  logic [3:0]  d1_ostate;
  logic [0:0]  d1_stage_idx, d1_vec_idx, d1_tap_idx;
  logic [15:0] d1_stall_cnt;

  ctrl_poly_fsm #(.NUM_STAGES(1), .NUM_VECTORS(1), .NUM_TAPS(1)) dut1 (
    .clk        (clk),
    .rst        (rst),
    .en         (d1_en),
    .flush      (d1_flush),
    .in_valid   (d1_in_valid),
    .in_ready   (d1_in_ready),
    .out_valid  (d1_out_valid),
    .out_ready  (d1_out_ready),
    .ostate     (d1_ostate),
    .stage_idx  (d1_stage_idx),
    .vec_idx    (d1_vec_idx),
    .tap_idx    (d1_tap_idx),
    .busy       (d1_busy),
    .frame_done (d1_frame_done),
    .stall_cnt  (d1_stall_cnt)
  );

  // --------------------------------------------------------------------------
  // Scoreboard
  // --------------------------------------------------------------------------
  int checks = 0;
  int errors = 0;
  int ov_cnt = 0;
  int fd_cnt = 0;
  logic [7:0] exp_q[$];

  function automatic logic [7:0] ev(input logic [3:0] st, input int v, input int s);
    return {st, v[1:0], s[1:0]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Bounded wait (sampled on negedge) for the main DUT to show state s.
  task automatic wait_state(input logic [3:0] s, input int budget, input string name);
    int n;
    n = 0;
    @(negedge clk);
    while (ostate !== s && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (ostate !== s) begin
      checks++;
      errors++;
      $display("FAIL %s: state %0d not reached, stuck at %0d", name, s, ostate);
    end
  endtask

  // Monitor: every output transfer and every frame_done pulse pops one
  // expected {ostate, vec_idx, stage_idx} record.
  initial begin
    logic [7:0] got, e;
    forever begin
      @(negedge clk);
      if (rst === 1'b1) begin
        if (out_valid) ov_cnt++;
        if (frame_done) fd_cnt++;
        if ((out_valid && out_ready && en && !flush) || frame_done) begin
          got = {ostate, 2'(vec_idx), 2'(stage_idx)};
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL sb_unexpected: got event %0h expected none", got);
          end else begin
            e = exp_q.pop_front();
            if (got !== e) begin
              errors++;
              $display("FAIL sb_event: got %0h expected %0h", got, e);
            end
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // --------------------------------------------------------------------------
  // Stimulus
  // --------------------------------------------------------------------------
  initial begin
    int t0, ov0, fd0, n, exp_stall;
    logic [3:0] seq1 [8];
    seq1 = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8};
`ifdef CTRL_STALL_CNT_EN
    exp_stall = 10;
`else
    exp_stall = 0;
`endif

    rst = 1'b0; en = 1'b1; flush = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    d1_en = 1'b1; d1_flush = 1'b0; d1_in_valid = 1'b1; d1_out_ready = 1'b1;

    // Reset state
    #1;
    check("rst_ostate", 32'(ostate), 0);
    check("rst_idx", {stage_idx, vec_idx, tap_idx}, 0);
    check("rst_hs", {in_ready, out_valid, frame_done, busy}, 0);
    check("rst_stall", 32'(stall_cnt), 0);

    // Frame 1: always-ready handshakes
    exp_q.push_back(ev(4'd6, 0, 3));
    exp_q.push_back(ev(4'd6, 1, 3));
    exp_q.push_back(ev(4'd7, 1, 3));
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    wait_state(4'd1, 10, "first_alloc");
    t0 = cyc; ov0 = ov_cnt; fd0 = fd_cnt;
    wait_state(4'd7, 200, "frame1_load_in");
    check("frame_done_time", 32'(cyc - t0), 169);
    wait_state(4'd1, 10, "frame1_end");
    check("frame_len", 32'(cyc - t0), 171);
    check("ov_cycles", 32'(ov_cnt - ov0), 2);
    check("fd_pulses", 32'(fd_cnt - fd0), 1);

    // Frame 2: output stall in LOAD_OUT
    @(posedge clk); #1;
    out_ready = 1'b0; in_valid = 1'b0;
    exp_q.push_back(ev(4'd6, 0, 3));
    exp_q.push_back(ev(4'd6, 1, 3));
    wait_state(4'd6, 200, "frame2_load_out");
    for (int i = 0; i < 10; i++) begin
      if (i > 0) @(negedge clk);
      check("stall_hold", {28'd0, ostate}, 6);
      check("stall_ov", 32'(out_valid), 1);
    end
    @(posedge clk); #1 out_ready = 1'b1;
    @(negedge clk);
    check("stall_cnt_out", 32'(stall_cnt), 32'(exp_stall));
    check("release_state", 32'(ostate), 6);
    @(negedge clk);
    check("release_pc_inc", 32'(ostate), 8);
    @(negedge clk);
    check("release_alloc", 32'(ostate), 1);
    check("release_vec", 32'(vec_idx), 1);
    check("release_stage", 32'(stage_idx), 0);

    // Clock enable toggled during CONV
    wait_state(4'd2, 5, "en_load_init");
    @(posedge clk); #1 en = 1'b0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      check("en_lo_tap", 32'(tap_idx), 32'(i));
      check("en_lo_state", 32'(ostate), 3);
      @(posedge clk); #1 en = 1'b1;
      @(negedge clk);
      check("en_hi_tap", 32'(tap_idx), 32'(i));
      check("en_hi_state", 32'(ostate), 3);
      @(posedge clk); #1 en = (i == 15);
    end
    @(negedge clk);
    check("conv_exit", 32'(ostate), 4);

    // Flush colliding with an input handshake
    wait_state(4'd6, 200, "frame2_out2");
    @(negedge clk);
    check("in_wait_state", 32'(ostate), 7);
    check("in_wait_ready", 32'(in_ready), 1);
    @(posedge clk); #1;
    in_valid = 1'b1; flush = 1'b1;
    @(negedge clk);
    check("flush_fd", 32'(frame_done), 0);
    check("stall_cnt_in", 32'(stall_cnt), 32'(exp_stall == 0 ? 0 : exp_stall + 1));
    @(posedge clk); #1 flush = 1'b0;
    @(negedge clk);
    check("flush_state", 32'(ostate), 0);
    check("flush_idx", {stage_idx, vec_idx, tap_idx}, 0);
    check("flush_busy", 32'(busy), 0);
    check("flush_stall", 32'(stall_cnt), 0);
    check("sb_drained", 32'(exp_q.size()), 0);

    // Asynchronous reset mid-CONV at tap 7
    n = 0;
    while (!(ostate == 4'd3 && tap_idx == 4'd7) && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("reach_tap7", 32'(tap_idx), 7);
    #2 rst = 1'b0;
    #1;
    check("arst_state", 32'(ostate), 0);
    check("arst_idx", {stage_idx, vec_idx, tap_idx}, 0);
    check("arst_hs", {in_ready, out_valid, busy}, 0);
    en = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    check("en_off_hold", 32'(ostate), 0);

    // Degenerate counts: period-8 sequence
    n = 0;
    while (d1_ostate !== 4'd1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    for (int i = 0; i < 8; i++) begin
      check("d1_seq", 32'(d1_ostate), 32'(seq1[i]));
      if (i == 5) check("d1_out_valid", 32'(d1_out_valid), 1);
      if (i == 6) check("d1_frame_done", 32'(d1_frame_done), 1);
      @(negedge clk);
    end
    check("d1_period", 32'(d1_ostate), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
